keypad_scanner: RTL and testbench

//   Input-side counterpart of the seven-segment scan controller: drives the 4x4

---
 rtl/keypad_scanner.sv | 144 ++++++++++++++
 tb/tb_keypad_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, synchronizes and debounces rows,
// and emits one hex key code per distinct press; multi-key scans are ignored.
module keypad_scanner #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned DIV_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DWELL - 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ResNone, ResKey, ResMulti} res_e;
  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    unique case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q;
  logic [1:0]       hits_q, hit_cnt;
  logic [3:0]       first_q, first_code;
  res_e             prev_kind_q, res_kind;
  logic [3:0]       prev_code_q, res_code;
  logic [STB_W-1:0] stable_q, stable_next;
  state_e           state_q, state_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             tick, scan_done, same;

  assign tick      = (div_q == DIV_MAX);
  assign scan_done = tick && (col_idx_q == 2'd3);
  assign col_idx_d = col_idx_q + 2'd1;

  // Fold this column's rows into the running scan; hit count saturates at 2 (MULTI).
  always_comb begin
    hit_cnt    = hits_q;
    first_code = first_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        if (hit_cnt == 2'd0) first_code = key_map(2'(r), col_idx_q);
        if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
      end
    end
    res_kind = (hit_cnt == 2'd0) ? ResNone : ((hit_cnt == 2'd1) ? ResKey : ResMulti);
    res_code = (res_kind == ResKey) ? first_code : 4'h0;
    same     = (res_kind == prev_kind_q) && (res_code == prev_code_q);
    if (!same)                  stable_next = STB_W'(1);
    else if (stable_q == STB_MAX) stable_next = STB_MAX;
    else                        stable_next = stable_q + STB_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (res_kind == ResKey && stable_next == STB_MAX) begin
            key_code_d  = res_code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = StHeld;
          end
        end
        StHeld: begin
          if (!(res_kind == ResKey && res_code == key_code_q) && stable_next == STB_MAX) begin
            key_held_d = 1'b0;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      hits_q      <= 2'd0;
      first_q     <= 4'h0;
      prev_kind_q <= ResNone;
      prev_code_q <= 4'h0;
      stable_q    <= '0;
      state_q     <= StIdle;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_sync_q  <= row_meta_q;
      div_q       <= tick ? '0 : div_q + DIV_W'(1);
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      if (tick) begin
        col_idx_q <= col_idx_d;
        col_q     <= ~(4'b0001 << col_idx_d);
        hits_q    <= scan_done ? 2'd0 : hit_cnt;
        first_q   <= scan_done ? 4'h0 : first_code;
      end
      if (scan_done) begin
        prev_kind_q <= res_kind;
        prev_code_q <= res_code;
        stable_q    <= stable_next;
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model driven by col, expected key
// codes queued at each press and popped whenever key_valid pulses.
module tb_keypad_scanner;

  logic       clk, rst;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys;  // keys[r*4+c] = key at (row r, col c) pressed
  int checks, failures, pulses;
  logic [3:0] exp_q[$];
  logic [3:0] col_exp [5];

  keypad_scanner #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; any key_valid pulse is matched against the scoreboard.
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed_code=%0h expected=no_pulse", key_code);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_code", 32'(key_code), 32'(e));
      end
    end
  endtask

  task automatic wait_pulse(input int maxc, output int n);
    int p0;
    p0 = pulses;
    n = 0;
    while (pulses == p0 && n < maxc) begin
      tick();
      n++;
    end
    check("pulse_seen", 32'(pulses != p0), 32'd1);
  endtask

  // Returns just after the edge where col wraps back to 1110 (divider at 0).
  task automatic wait_scan_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      prev = col;
      tick();
      if (col == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    check("scan_start", 32'(found), 32'd1);
  endtask

  initial begin
    int n, p;
    checks = 0; failures = 0; pulses = 0;
    keys = '0;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1;
    #12 rst = 1'b0;

    // 1: async reset mid-cycle, then column walk
    repeat (25) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_col", 32'(col), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    #3 rst = 1'b0;
    repeat (5) tick();
    check("col_step0", 32'(col), 32'(col_exp[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (10) tick();
      check("col_step", 32'(col), 32'(col_exp[i]));
    end

    // 2: steady '5'
    wait_scan_start();
    keys[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_pulse(130, n);
    check("lat5_lo", 32'(n >= 80), 32'd1);
    check("lat5_hi", 32'(n <= 122), 32'd1);
    check("held5", 32'(key_held), 32'd1);
    p = pulses;
    repeat (1000) tick();
    check("no_repeat5", 32'(pulses), 32'(p));
    check("code5_hold", 32'(key_code), 32'h5);

    // 4: release '5', press 'D', release and re-press 'D'
    keys = '0;
    repeat (122) tick();
    check("rel5_held", 32'(key_held), 32'd0);
    check("rel5_code", 32'(key_code), 32'h5);
    wait_scan_start();
    keys[15] = 1'b1;
    exp_q.push_back(4'hD);
    wait_pulse(130, n);
    check("latD_hi", 32'(n <= 122), 32'd1);
    keys = '0;
    repeat (122) tick();
    check("relD_held", 32'(key_held), 32'd0);
    wait_scan_start();
    keys[15] = 1'b1;
    exp_q.push_back(4'hD);
    wait_pulse(130, n);
    check("latD2_lo", 32'(n >= 80), 32'd1);
    check("heldD2", 32'(key_held), 32'd1);
    keys = '0;
    repeat (130) tick();

    // 3: bounce '0' every 7 clk, then hold
    wait_scan_start();
    p = pulses;
    for (int j = 0; j < 14; j++) begin
      keys[12] = j[0];
      repeat (7) tick();
    end
    check("bounce_no_pulse", 32'(pulses), 32'(p));
    keys[12] = 1'b1;
    exp_q.push_back(4'h0);
    wait_pulse(250, n);
    p = pulses;
    repeat (200) tick();
    check("bounce_single", 32'(pulses), 32'(p));
    check("held0", 32'(key_held), 32'd1);
    keys = '0;
    repeat (150) tick();

    // 5: ghosting guard, then release '2'
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    p = pulses;
    repeat (1000) tick();
    check("multi_no_pulse", 32'(pulses), 32'(p));
    check("multi_held", 32'(key_held), 32'd0);
    keys[1] = 1'b0;
    exp_q.push_back(4'h1);
    wait_pulse(130, n);
    check("held1", 32'(key_held), 32'd1);
    keys = '0;
    repeat (150) tick();

    // 6: reset mid-hold of 'A'
    keys[3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_pulse(170, n);
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    check("rstA_code", 32'(key_code), 32'h0);
    check("rstA_held", 32'(key_held), 32'd0);
    check("rstA_col", 32'(col), 32'hE);
    repeat (3) tick();
    check("rstA_held_in", 32'(key_held), 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'hA);
    wait_pulse(130, n);
    check("latA_lo", 32'(n >= 80), 32'd1);
    check("latA_hi", 32'(n <= 122), 32'd1);
    check("heldA", 32'(key_held), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
